packed_elem_reader: RTL and testbench
=====================================

PACKED_ELEM_READER -- requirements
Module: packed_elem_reader

Interface
REQ-001 Parameter ROWS, default 2: outer packed dimension of the word type.
REQ-002 Parameter COLS, default 3: inner packed dimension of the word type.
REQ-003 Parameter EW, default 1: element width in bits.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  packed word offered.
REQ-007 in_ready  output  1  block accepts a word.
REQ-008 in_data  input  ROWS*COLS*EW  packed word; element [r][c] at bits r*COLS*EW + c*EW + EW-1 down to r*COLS*EW + c*EW.
REQ-009 out_valid  output  1  element presented.
REQ-010 out_ready  input  1  sink accepts element.
REQ-011 out_data  output  EW  current element value.
REQ-012 out_row  output  clog2(ROWS), min 1  row index of current element.
REQ-013 out_col  output  clog2(COLS), min 1  column index of current element.
REQ-014 out_last  output  1  current element is [ROWS-1][COLS-1].
REQ-015 skip_zero  input  1  when high at word acceptance, all-zero elements are not emitted for that word.
REQ-016 words_done  output  16  count of fully drained words, wraps 0xFFFF->0.

Function
REQ-017 FSM states: IDLE, SEND; IDLE is the reset state.
REQ-018 in_ready high exactly in IDLE; in_ready low in SEND.
REQ-019 In IDLE with in_valid high: capture in_data and skip_zero into internal registers, load index to the first emitted element, and go to SEND next cycle.
REQ-020 Emission order: row 0 first; column increments fastest; after col COLS-1, col wraps to 0 and row increments.
REQ-021 In SEND, out_valid high; out_data, out_row, out_col, out_last stable while out_valid && !out_ready.
REQ-022 Element transfer occurs on out_valid && out_ready; the index advances on the same edge.
REQ-023 With captured skip_zero high, index advances to the next nonzero element; zero elements produce no out_valid cycle.
REQ-024 With skip_zero high, out_last marks the last nonzero element of the word, not necessarily [ROWS-1][COLS-1].
REQ-025 A word with skip_zero high and all elements zero: accepted, no element emitted, FSM stays in IDLE, words_done increments one cycle after acceptance.
REQ-026 Transfer with out_last high: return to IDLE next cycle; words_done increments on the same edge.
REQ-027 Latency: first out_valid one cycle after the in_valid/in_ready handshake; one element per cycle at sustained out_ready; ROWS*COLS+1 cycles per word without skipping.
REQ-028 in_data and skip_zero changes during SEND have no effect.
REQ-029 Reset outputs: in_ready 1 after reset release; out_valid 0, out_data 0, out_row 0, out_col 0, out_last 0, words_done 0.
REQ-030 ROWS=1 or COLS=1 legal; index widths clamp to 1 bit.

Reset
REQ-031 rst_n low asynchronously clears all registers to REQ-029 values, including mid-word; the partial word is discarded and no out_valid follows.
REQ-032 First acceptance possible on the first rising edge with rst_n high.

Structure
REQ-033 Shared package pkg_packed_elem holds the state enum and the parameterised word typedef (ROWS x COLS x EW packed) shared with the matching writer.
REQ-034 One sub-module, packed_elem_next_idx: combinational next-nonzero-index search over the captured word, honouring skip flag.

Verification
REQ-035 Defaults, skip_zero=0, in_data=6'b000010, out_ready=1 -> six elements (0,0)=0,(0,1)=1,(0,2)=0,(1,0)=0,(1,1)=0,(1,2)=0 on consecutive cycles; out_last on 6th; words_done=1.
REQ-036 Same word, skip_zero=1 -> exactly one element: row 0, col 1, data 1, out_last 1.
REQ-037 in_data=6'b000000, skip_zero=1 -> no out_valid; in_ready stays high; words_done +1.
REQ-038 out_ready toggled 1,0,0,1,... during in_data=6'b101101 -> outputs held during stalls; sequence 1,0,1,1,0,1 in order.
REQ-039 rst_n low after third element transfer -> out_valid 0 immediately, in_ready 1 after release, next word emits from (0,0).
REQ-040 Preload words_done to 0xFFFF via 65535 words (skip_zero=1, zero data) then one more -> words_done=0.

Source files
------------

// File: rtl/packed_elem_reader_pkg.sv
// Shared types for the packed-element reader/writer pair: FSM state encoding,
// default word layout and index-width helpers.
package pkg_packed_elem;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int DEF_ROWS = 2;
    localparam int DEF_COLS = 3;
    localparam int DEF_EW   = 1;

    typedef logic [DEF_ROWS-1:0][DEF_COLS-1:0][DEF_EW-1:0] word_t;

    // Index width for a dimension of n entries; a single entry still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a linear element index that must also hold the one-past-end value n.
    function automatic int lin_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/packed_elem_next_idx.sv
// Combinational search for the first emitted element at or after start_lin,
// plus whether any further emitted element follows it in the same word.
module packed_elem_next_idx
    import pkg_packed_elem::*;
#(
    parameter int ROWS = 2,
    parameter int COLS = 3,
    parameter int EW   = 1,
    parameter int RW   = idx_w(ROWS),
    parameter int CW   = idx_w(COLS),
    parameter int LW   = lin_w(ROWS * COLS)
) (
    input  logic [ROWS*COLS*EW-1:0] word,
    input  logic                    skip,
    input  logic [LW-1:0]           start_lin,
    output logic                    found,
    output logic                    more,
    output logic [LW-1:0]           sel_lin,
    output logic [RW-1:0]           sel_row,
    output logic [CW-1:0]           sel_col,
    output logic [EW-1:0]           sel_data
);

    typedef logic [ROWS-1:0][COLS-1:0][EW-1:0] word_pt;

    word_pt elems_s;
    assign elems_s = word;

    // Scan from the highest index down so the lowest qualifying index wins.
    always_comb begin
        found    = 1'b0;
        more     = 1'b0;
        sel_lin  = '0;
        sel_row  = '0;
        sel_col  = '0;
        sel_data = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            for (int c = COLS - 1; c >= 0; c--) begin
                found    = found | (((r * COLS + c) >= int'(start_lin)) &&
                                    (!skip || (elems_s[r][c] != '0)));
                sel_lin  = (((r * COLS + c) >= int'(start_lin)) && (!skip || (elems_s[r][c] != '0)))
                           ? LW'(r * COLS + c) : sel_lin;
                sel_row  = (((r * COLS + c) >= int'(start_lin)) && (!skip || (elems_s[r][c] != '0)))
                           ? RW'(r) : sel_row;
                sel_col  = (((r * COLS + c) >= int'(start_lin)) && (!skip || (elems_s[r][c] != '0)))
                           ? CW'(c) : sel_col;
                sel_data = (((r * COLS + c) >= int'(start_lin)) && (!skip || (elems_s[r][c] != '0)))
                           ? elems_s[r][c] : sel_data;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                more = more | (found && ((r * COLS + c) > int'(sel_lin)) &&
                               (!skip || (elems_s[r][c] != '0)));
            end
        end
    end

endmodule

// File: rtl/packed_elem_reader.sv
// Accepts a ROWS x COLS packed word and streams its elements row-major with
// valid/ready, optionally skipping all-zero elements; counts drained words.
module packed_elem_reader
    import pkg_packed_elem::*;
#(
    parameter int ROWS = 2,
    parameter int COLS = 3,
    parameter int EW   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*COLS*EW-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EW-1:0]             out_data,
    output logic [idx_w(ROWS)-1:0]    out_row,
    output logic [idx_w(COLS)-1:0]    out_col,
    output logic                      out_last,
    input  logic                      skip_zero,
    output logic [15:0]               words_done
);

    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    localparam int LW = lin_w(ROWS * COLS);
    localparam int WW = ROWS * COLS * EW;

    state_e          state_r, state_nxt_s;
    logic [WW-1:0]   word_r;
    logic            skip_r;
    logic [LW-1:0]   cur_lin_r;
    logic            out_valid_r, out_last_r, in_ready_s;
    logic [EW-1:0]   out_data_r;
    logic [RW-1:0]   out_row_r;
    logic [CW-1:0]   out_col_r;
    logic [15:0]     words_done_r;

    logic [WW-1:0]   src_word_s;
    logic            src_skip_s;
    logic [LW-1:0]   src_start_s;
    logic            found_s, more_s;
    logic [LW-1:0]   sel_lin_s;
    logic [RW-1:0]   sel_row_s;
    logic [CW-1:0]   sel_col_s;
    logic [EW-1:0]   sel_data_s;
    logic            accept_s, xfer_s, load_s, word_end_s;

    assign accept_s   = in_ready_s && in_valid;
    assign xfer_s     = out_valid_r && out_ready;
    assign load_s     = (accept_s && found_s) || (xfer_s && !out_last_r);
    assign word_end_s = (accept_s && !found_s) || (xfer_s && out_last_r);

    // In IDLE the search looks at the word being offered so the first element is ready next cycle.
    always_comb begin
        if (state_r == IDLE) begin
            src_word_s  = in_data;
            src_skip_s  = skip_zero;
            src_start_s = '0;
        end else begin
            src_word_s  = word_r;
            src_skip_s  = skip_r;
            src_start_s = cur_lin_r + LW'(1);
        end
    end

    packed_elem_next_idx #(
        .ROWS (ROWS),
        .COLS (COLS),
        .EW   (EW)
    ) u_next_idx (
        .word      (src_word_s),
        .skip      (src_skip_s),
        .start_lin (src_start_s),
        .found     (found_s),
        .more      (more_s),
        .sel_lin   (sel_lin_s),
        .sel_row   (sel_row_s),
        .sel_col   (sel_col_s),
        .sel_data  (sel_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; an all-skipped word never leaves IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = (in_valid && found_s) ? SEND : IDLE;
            SEND:    state_nxt_s = (out_ready && out_last_r) ? IDLE : SEND;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = 1'b1;
            SEND:    in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Captured word, current element registers and drained-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r       <= '0;
            skip_r       <= 1'b0;
            cur_lin_r    <= '0;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_row_r    <= '0;
            out_col_r    <= '0;
            out_last_r   <= 1'b0;
            words_done_r <= 16'd0;
        end else begin
            if (accept_s) begin
                word_r <= in_data;
                skip_r <= skip_zero;
            end
            if (load_s) begin
                cur_lin_r   <= sel_lin_s;
                out_valid_r <= 1'b1;
                out_data_r  <= sel_data_s;
                out_row_r   <= sel_row_s;
                out_col_r   <= sel_col_s;
                out_last_r  <= !more_s;
            end else if (xfer_s) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
            if (word_end_s) begin
                words_done_r <= words_done_r + 16'd1;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_row    = out_row_r;
    assign out_col    = out_col_r;
    assign out_last   = out_last_r;
    assign words_done = words_done_r;

endmodule

// File: tb/tb_packed_elem_reader.sv
// Directed self-checking bench for packed_elem_reader at default parameters (2x3, 1-bit).
module tb_packed_elem_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_data = 6'b000000;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [0:0] out_data;
    logic [0:0] out_row;
    logic [1:0] out_col;
    logic       out_last;
    logic       skip_zero = 1'b0;
    logic [15:0] words_done;

    int tests_run = 0;
    int tests_failed = 0;

    packed_elem_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .skip_zero  (skip_zero),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_elem(input string tag, input int row, input int col, input int data, input int last);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_row"},   32'(out_row),   32'(row));
        check({tag, "_col"},   32'(out_col),   32'(col));
        check({tag, "_data"},  32'(out_data),  32'(data));
        check({tag, "_last"},  32'(out_last),  32'(last));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_row [6] = '{0, 0, 0, 1, 1, 1};
    int exp_col [6] = '{0, 1, 2, 0, 1, 2};
    int exp_a   [6] = '{0, 1, 0, 0, 0, 0};
    int exp_b   [6] = '{1, 0, 1, 1, 0, 1};
    int idx;
    int cyc;

    initial begin
        // Reset values while rst_n is held low.
        #12;
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_data",   32'(out_data),   32'd0);
        check("rst_out_row",    32'(out_row),    32'd0);
        check("rst_out_col",    32'(out_col),    32'd0);
        check("rst_out_last",   32'(out_last),   32'd0);
        check("rst_words_done", 32'(words_done), 32'd0);
        rst_n = 1'b1;

        // Plain word 000010, no skipping, sink always ready.
        in_valid  = 1'b1;
        in_data   = 6'b000010;
        skip_zero = 1'b0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("plain_in_ready_busy", 32'(in_ready), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check_elem("plain", exp_row[i], exp_col[i], exp_a[i], (i == 5) ? 1 : 0);
            step();
        end
        check("plain_end_valid", 32'(out_valid),  32'd0);
        check("plain_end_ready", 32'(in_ready),   32'd1);
        check("plain_words",     32'(words_done), 32'd1);

        // Same word with skip_zero: only (0,1) is emitted and it is last.
        in_valid  = 1'b1;
        skip_zero = 1'b1;
        step();
        in_valid  = 1'b0;
        skip_zero = 1'b0;
        check_elem("skip", 0, 1, 1, 1);
        step();
        check("skip_end_valid", 32'(out_valid),  32'd0);
        check("skip_words",     32'(words_done), 32'd2);

        // All-zero word with skip_zero: consumed without any element.
        in_valid  = 1'b1;
        in_data   = 6'b000000;
        skip_zero = 1'b1;
        step();
        in_valid  = 1'b0;
        skip_zero = 1'b0;
        check("zero_valid", 32'(out_valid),  32'd0);
        check("zero_ready", 32'(in_ready),   32'd1);
        check("zero_words", 32'(words_done), 32'd3);
        step();
        check("zero_valid_later", 32'(out_valid), 32'd0);

        // Back-pressure: out_ready pattern 1,0,0,1 repeating on word 101101.
        in_valid = 1'b1;
        in_data  = 6'b101101;
        step();
        in_valid = 1'b0;
        in_data  = 6'b111111;
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 40) begin
            check_elem("stall", exp_row[idx], exp_col[idx], exp_b[idx], (idx == 5) ? 1 : 0);
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            step();
            if (out_ready) idx++;
            cyc++;
        end
        check("stall_count", 32'(idx), 32'd6);
        out_ready = 1'b1;
        check("stall_end_valid", 32'(out_valid),  32'd0);
        check("stall_words",     32'(words_done), 32'd4);

        // Reset in the middle of a word after three transfers.
        in_valid = 1'b1;
        in_data  = 6'b000010;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check_elem("pre_rst", 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid),  32'd0);
        check("midrst_row",   32'(out_row),    32'd0);
        check("midrst_words", 32'(words_done), 32'd0);
        rst_n = 1'b1;
        check("midrst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 6'b000001;
        step();
        in_valid = 1'b0;
        check_elem("post_rst_first", 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step();
        check_elem("post_rst_last", 1, 2, 0, 1);
        step();
        check("post_rst_words", 32'(words_done), 32'd1);

        // Counter wrap: empty skipped words back to back.
        in_valid  = 1'b1;
        in_data   = 6'b000000;
        skip_zero = 1'b1;
        for (int i = 0; i < 65534; i++) step();
        check("wrap_ffff",  32'(words_done), 32'h0000FFFF);
        check("wrap_valid", 32'(out_valid),  32'd0);
        step();
        in_valid = 1'b0;
        check("wrap_zero", 32'(words_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
